multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Iterative signed 32-bit multiply/divide unit that produces results for the P/W writeback latch.
- Started by the execute-stage start pulses. Returns a 32-bit result, an exception flag and a one-cycle ready pulse.
- Holds the result stable until the next start, so the P/W latch can capture it when ready is signalled.
- Exposes busy, which the hazard logic uses to stall dependent instructions.

Parameters:
- WIDTH, 32: operand and result width in bits. The iteration count equals WIDTH.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ctrl_MULT  in  1  start-multiply pulse
- ctrl_DIV  in  1  start-divide pulse
- data_operandA  in  WIDTH  multiplicand / dividend, sampled on the start edge
- data_operandB  in  WIDTH  multiplier / divisor, sampled on the start edge
- data_result  out  WIDTH  product low word or quotient
- data_exception  out  1  overflow / divide-by-zero flag, valid with data_result
- data_resultRDY  out  1  one-cycle pulse when data_result and data_exception are valid
- busy  out  1  high while an operation is in progress

Behaviour:
- Reset:
  - state=IDLE, counter=0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset wins over any simultaneous start.
  - Reset mid-operation discards the operation; no ready pulse is produced.
- States: IDLE → RUN → FIX → DONE → IDLE.
- IDLE:
  - On a rising edge with ctrl_MULT or ctrl_DIV high, latch the operands and the operation, go to RUN, busy=1.
  - Operands are converted to magnitudes; the result sign is recorded.
  - If ctrl_MULT and ctrl_DIV are both high, the operation is MULT.
- RUN, WIDTH cycles, counter 0..WIDTH-1:
  - MULT: shift-add on magnitudes into a 2*WIDTH accumulator.
  - DIV: restoring division on magnitudes producing quotient and remainder.
  - After the final iteration go to FIX.
- FIX, 1 cycle:
  - Apply the sign. Division truncates toward zero; the remainder is discarded.
  - Set data_result and data_exception. Go to DONE.
- DONE:
  - data_resultRDY=1 for exactly this cycle, busy=0. Then IDLE.
  - Latency: start sampled at edge N; data_resultRDY is high in the cycle following edge N+WIDTH+2.
  - For WIDTH=32 that is 34 edges after the start edge.
- data_result and data_exception hold their values from FIX until the next FIX or reset. They are not cleared on a new start.
- Start while busy (RUN or FIX): abort the current operation, latch the new operands and operation, restart RUN at counter=0. The aborted operation produces no ready pulse.
- A start in the DONE cycle is accepted normally; the ready pulse for the finishing operation is still emitted.
- Exceptions:
  - MULT: exception=1 if the signed 2*WIDTH product does not fit in WIDTH bits. data_result = low WIDTH bits.
  - DIV by zero: exception=1, data_result=0.
  - DIV of 0x80000000 by -1: exception=1, data_result=0x80000000.
  - 0x80000000 as a multiply operand: handle its magnitude as unsigned 2^31, with no internal overflow.

Optional Feature:
- Macro: MULTDIV_DIV0_EARLY_EN.
- Defined: a DIV start with data_operandB=0 skips RUN and goes directly to FIX. data_resultRDY pulses 2 edges after the start edge, with exception=1 and result=0.
- Not defined: divide-by-zero takes the full WIDTH+2 latency, with the same result and exception values.
- A zero-operand MULT is never shortened in either build.

Decomposition:
- Package multdiv_pkg:
  - State enum: IDLE, RUN, FIX, DONE.
  - Operation enum: OP_MULT, OP_DIV.
  - Constant MULTDIV_WIDTH=32.
  - Constant MULTDIV_MIN = 0x80000000.
- One sub-module, multdiv_iter_core: the unsigned magnitude datapath (shift-add / restoring-divide step, accumulator and quotient registers).
- multdiv_sequencer keeps the FSM, counter, sign handling, exception logic and output registers.

Test Plan:
- MULT 6 × 7: data_resultRDY pulses once, 34 edges after start; result=42, exception=0; busy low afterwards.
- MULT -6 × 7 gives result=0xFFFFFFD6 (-42), exception=0. MULT 0x40000000 × 4 gives result=0, exception=1.
- DIV 100 / -7 gives result=-14, exception=0. DIV -100 / 7 gives -14. DIV 0x80000000 / -1 gives result=0x80000000, exception=1.
- DIV 5 / 0:
  - Without the macro: ready at 34 edges, result=0, exception=1.
  - With MULTDIV_DIV0_EARLY_EN: ready at 2 edges, same values.
- Start MULT 3 × 3, then at edge +10 start DIV 81 / 9: exactly one ready pulse, 34 edges after the second start, result=9.
- Start MULT 2 × 2, assert reset at edge +5: all outputs 0, busy=0, no ready pulse. A subsequent MULT 2 × 2 returns 4.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional build macro used by the sequencer: MULTDIV_DIV0_EARLY_EN.
package multdiv_pkg;

    localparam int          MULTDIV_WIDTH = 32;
    localparam logic [31:0] MULTDIV_MIN   = 32'h8000_0000;

    // Sequencer states, in the order an operation walks through them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Operation latched at start.
    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_iter_core.sv
// Unsigned magnitude datapath: one shift-add (multiply) or one restoring
// subtract (divide) step per cycle over a shared 2*WIDTH accumulator.
// Multiply: acc = {partial_hi, multiplier}, the multiplier shifts out of
//           the low half while the product shifts in from the top.
// Divide:   acc = {remainder, dividend/quotient}, the dividend shifts out
//           of the low half while quotient bits shift in at bit 0.
module multdiv_iter_core
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULTDIV_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  op_e                  op_sel,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic [2*WIDTH-1:0]   acc
);

    op_e              op_q;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH-1:0] acc_next;

    logic [WIDTH:0]   mult_sum;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH+1:0] div_diff;

    // Next accumulator value for one iteration of the latched operation.
    always_comb begin
        mult_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        div_shifted = acc[2*WIDTH-1:WIDTH-1];
        div_diff    = {1'b0, div_shifted} - {2'b00, opnd};
        acc_next    = acc;
        if (op_q == OP_MULT) begin
            acc_next = {mult_sum, acc[WIDTH-1:1]};
        end else if (!div_diff[WIDTH+1]) begin
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {div_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Load operands on start, otherwise advance one step while running.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
            op_q <= OP_MULT;
        end else if (load) begin
            op_q <= op_sel;
            if (op_sel == OP_MULT) begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                opnd <= mag_a;
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_a};
                opnd <= mag_b;
            end
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide sequencer feeding the P/W latch.
// Build option: define MULTDIV_DIV0_EARLY_EN to finish divide-by-zero
// without running the iteration loop.
//
// Handshake: ctrl_MULT/ctrl_DIV are start pulses accepted in any cycle
// (a start while busy aborts and restarts); there is no backpressure.
// data_resultRDY is a single-cycle strobe; data_result/data_exception
// stay stable from the FIX update until the next FIX update or reset.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULTDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_FIX  = FIX;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    op_e              op_q;
    logic             res_neg_q;
    logic             b_zero_q;
    logic             div_ovf_q;

    logic             start;
    op_e              start_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*WIDTH-1:0] core_acc;

    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_exc;

    // MULT wins when both start pulses arrive together.
    assign start    = ctrl_MULT | ctrl_DIV;
    assign start_op = ctrl_MULT ? OP_MULT : OP_DIV;

    // Magnitudes; the minimum value maps onto unsigned 2^(WIDTH-1).
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign busy      = (state == ST_RUN) || (state == ST_FIX);
    assign dbg_state = state;

    multdiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (start),
        .step   ((state == ST_RUN) && !start),
        .op_sel (start_op),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc    (core_acc)
    );

    // Sign application and exception detection for the FIX cycle.
    always_comb begin
        prod_signed = res_neg_q ? -core_acc : core_acc;
        quo_signed  = res_neg_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
        prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
        fix_result  = '0;
        fix_exc     = 1'b0;
        if (op_q == OP_MULT) begin
            fix_result = prod_signed[WIDTH-1:0];
            fix_exc    = !((&prod_top) || !(|prod_top));
        end else if (b_zero_q) begin
            fix_result = '0;
            fix_exc    = 1'b1;
        end else begin
            fix_result = quo_signed;
            fix_exc    = div_ovf_q;
        end
    end

    // Control FSM, iteration counter and held result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            counter        <= '0;
            op_q           <= OP_MULT;
            res_neg_q      <= 1'b0;
            b_zero_q       <= 1'b0;
            div_ovf_q      <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            // The finishing operation still strobes even if a new start lands in DONE.
            data_resultRDY <= (state == ST_DONE);
            if (start) begin
                op_q      <= start_op;
                res_neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                b_zero_q  <= (data_operandB == '0);
                div_ovf_q <= (data_operandA == MIN_VAL) && (&data_operandB);
                counter   <= '0;
                state     <= ST_RUN;
`ifdef MULTDIV_DIV0_EARLY_EN
                if ((start_op == OP_DIV) && (data_operandB == '0)) begin
                    state <= ST_FIX;
                end
`else
`endif
            end else begin
                case (state)
                    ST_RUN: begin
                        counter <= counter + CNT_W'(1);
                        if (counter == LAST) begin
                            counter <= '0;
                            state   <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        data_result    <= fix_result;
                        data_exception <= fix_exc;
                        state          <= ST_DONE;
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed cases, randomized
// operations against an arithmetic reference model, abort, start-in-DONE
// and mid-operation reset.
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int fails  = 0;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    // Reference model: {exception, result} from signed arithmetic.
    function automatic logic [32:0] model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q;
        logic [31:0] min_v;
        min_v = MULTDIV_MIN;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == min_v && b == 32'hFFFF_FFFF) return {1'b1, min_v};
        q = sa / sb;
        return {1'b0, q[31:0]};
    endfunction

    function automatic int exp_lat(input logic is_div, input logic [31:0] b);
`ifdef MULTDIV_DIV0_EARLY_EN
        if (is_div && b == 32'd0) return 2;
`endif
        return 34;
    endfunction

    // Driver: present a start for one edge; returns at the negedge after the start edge.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    endtask

    // Watch a bounded window of edges after a start for ready pulses.
    task automatic watch(input int window, output int lat, output int pulses,
                         output logic [31:0] res, output logic exc,
                         output logic busy_rdy, output logic busy_early);
        lat = -1; pulses = 0; res = '0; exc = 1'b0; busy_rdy = 1'b1; busy_early = 1'b0;
        for (int k = 1; k <= window; k++) begin
            @(negedge clock);
            if (k == 1) busy_early = busy;
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    lat = k; res = data_result; exc = data_exception; busy_rdy = busy;
                end
            end
        end
    endtask

    // Run one op and check latency, single pulse, values and busy.
    task automatic run_and_check(input string name, input logic is_div, input logic [31:0] a, input logic [31:0] b);
        int lat, pulses, el;
        logic [31:0] res;
        logic exc, brdy, bearly;
        logic [32:0] e;
        e  = model(is_div, a, b);
        el = exp_lat(is_div, b);
        issue(!is_div, is_div, a, b);
        watch(40, lat, pulses, res, exc, brdy, bearly);
        checks++;
        if (lat !== el || pulses !== 1) begin
            fails++;
            $display("FAIL %s latency/pulses: got lat=%0d pulses=%0d, expected lat=%0d pulses=1", name, lat, pulses, el);
        end
        checks++;
        if (res !== e[31:0] || exc !== e[32]) begin
            fails++;
            $display("FAIL %s value: got %h exc=%b, expected %h exc=%b (a=%h b=%h)", name, res, exc, e[31:0], e[32], a, b);
        end
        checks++;
        if (brdy !== 1'b0 || bearly !== 1'b1) begin
            fails++;
            $display("FAIL %s busy: got early=%b at_ready=%b, expected early=1 at_ready=0", name, bearly, brdy);
        end
        checks++;
        if (data_result !== e[31:0] || data_exception !== e[32] || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s hold: got %h exc=%b busy=%b, expected %h exc=%b busy=0", name, data_result, data_exception, busy, e[31:0], e[32]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset: got result=%h exc=%b rdy=%b busy=%b, expected all 0", data_result, data_exception, data_resultRDY, busy);
        end
        // Reset wins over a simultaneous start.
        ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_vs_start: got busy=%b, expected 0", busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_and_check("mult_6x7",        1'b0, 32'd6,          32'd7);
        run_and_check("mult_m6x7",       1'b0, -32'sd6,        32'd7);
        run_and_check("mult_ovf",        1'b0, 32'h4000_0000,  32'd4);
        run_and_check("mult_min_x_m1",   1'b0, MULTDIV_MIN,    32'hFFFF_FFFF);
        run_and_check("mult_min_x_1",    1'b0, MULTDIV_MIN,    32'd1);
        run_and_check("mult_zero",       1'b0, 32'd0,          32'd12345);
        run_and_check("div_100_m7",      1'b1, 32'd100,        -32'sd7);
        run_and_check("div_m100_7",      1'b1, -32'sd100,      32'd7);
        run_and_check("div_min_m1",      1'b1, MULTDIV_MIN,    32'hFFFF_FFFF);
        run_and_check("div_5_0",         1'b1, 32'd5,          32'd0);
        run_and_check("div_min_3",       1'b1, MULTDIV_MIN,    32'd3);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MULTDIV_MIN;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_and_check("random", 1'($urandom_range(0, 1)), pick_operand(), pick_operand());
        end
    endtask

    // Both start pulses high: treated as MULT.
    task automatic test_both_start();
        int lat, pulses;
        logic [31:0] res;
        logic exc, brdy, bearly;
        issue(1'b1, 1'b1, 32'd100, 32'd7);
        watch(40, lat, pulses, res, exc, brdy, bearly);
        checks++;
        if (lat !== 34 || pulses !== 1 || res !== 32'd700 || exc !== 1'b0) begin
            fails++;
            $display("FAIL both_start: got lat=%0d pulses=%0d res=%h exc=%b, expected lat=34 pulses=1 res=%h exc=0", lat, pulses, res, exc, 32'd700);
        end
    endtask

    // MULT 3x3 aborted at +10 by DIV 81/9.
    task automatic test_abort();
        int lat, pulses, early_pulses;
        logic [31:0] res;
        logic exc, brdy, bearly;
        early_pulses = 0;
        issue(1'b1, 1'b0, 32'd3, 32'd3);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) early_pulses++;
        end
        issue(1'b0, 1'b1, 32'd81, 32'd9);
        if (data_resultRDY === 1'b1) early_pulses++;
        watch(40, lat, pulses, res, exc, brdy, bearly);
        checks++;
        if (early_pulses + pulses !== 1 || lat !== 34 || res !== 32'd9 || exc !== 1'b0) begin
            fails++;
            $display("FAIL abort: got pulses=%0d lat=%0d res=%h exc=%b, expected pulses=1 lat=34 res=9 exc=0", early_pulses + pulses, lat, res, exc);
        end
    endtask

    // Start landing in the DONE cycle: old pulse still emitted, new op runs.
    task automatic test_done_start();
        int lat, pulses;
        logic [31:0] res;
        logic exc, brdy, bearly;
        logic old_rdy;
        logic [31:0] old_res;
        issue(1'b1, 1'b0, 32'd11, 32'd13);
        repeat (32) @(negedge clock);
        issue(1'b0, 1'b1, -32'sd50, 32'd5);
        old_rdy = data_resultRDY;
        old_res = data_result;
        checks++;
        if (old_rdy !== 1'b1 || old_res !== 32'd143) begin
            fails++;
            $display("FAIL done_start_old: got rdy=%b res=%h, expected rdy=1 res=%h", old_rdy, old_res, 32'd143);
        end
        watch(40, lat, pulses, res, exc, brdy, bearly);
        checks++;
        if (lat !== 34 || pulses !== 1 || res !== 32'hFFFF_FFF6 || exc !== 1'b0) begin
            fails++;
            $display("FAIL done_start_new: got lat=%0d pulses=%0d res=%h exc=%b, expected lat=34 pulses=1 res=fffffff6 exc=0", lat, pulses, res, exc);
        end
    endtask

    // Reset mid-operation discards it; later op works normally.
    task automatic test_reset_mid();
        int lat, pulses;
        logic [31:0] res;
        logic exc, brdy, bearly;
        issue(1'b1, 1'b0, 32'd2, 32'd2);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got result=%h exc=%b rdy=%b busy=%b, expected all 0", data_result, data_exception, data_resultRDY, busy);
        end
        reset = 1'b0;
        watch(40, lat, pulses, res, exc, brdy, bearly);
        checks++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_pulse: got pulses=%0d, expected 0", pulses);
        end
        run_and_check("after_reset_2x2", 1'b0, 32'd2, 32'd2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_both_start();
        test_abort();
        test_done_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
